// File: rtl/qk_result_buffer.sv
// qk_result_buffer: per-lane FIFOs for QK results, merged onto one round-robin output stream.
// Latency: a push into an idle, empty buffer shows up on out_valid one edge after the push edge.
// Backpressure: out_ready=0 freezes the presented result; a push into a full lane is dropped and flagged in overflow.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   write_enable[i]     - push request for lane i; lane i data is the i-th slice of QK_RESULT, lane 0 at the MSB end
//   IS_FULL[i]          - lane i holds DEPTH entries (decoded from registered counts only)
//   overflow[i]         - sticky: a push to lane i was dropped; cleared by clear_overflow
//   out_valid/out_ready - valid/ready handshake for out_data/out_lane
//   out_data, out_lane  - popped result and the lane it came from
module qk_result_buffer #(
    parameter int OUTPUT_WIDTH = 9,
    parameter int MATRIX_SIZE  = 3,
    parameter int DEPTH        = 4,   // power of two, >= 2
    localparam int LANE_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [MATRIX_SIZE-1:0]              write_enable,
    input  logic [MATRIX_SIZE*OUTPUT_WIDTH-1:0] QK_RESULT,
    output logic [MATRIX_SIZE-1:0]              IS_FULL,
    output logic [MATRIX_SIZE-1:0]              overflow,
    input  logic                                clear_overflow,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUTPUT_WIDTH-1:0]             out_data,
    output logic [LANE_W-1:0]                   out_lane
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [OUTPUT_WIDTH-1:0] r_mem    [MATRIX_SIZE][DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr [MATRIX_SIZE];
    logic [PTR_W-1:0]        r_rd_ptr [MATRIX_SIZE];
    logic [CNT_W-1:0]        r_count  [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0]  r_overflow;

    state_t                  r_state;
    logic [LANE_W-1:0]       r_rr_ptr;
    logic                    r_out_valid;
    logic [OUTPUT_WIDTH-1:0] r_out_data;
    logic [LANE_W-1:0]       r_out_lane;

    // ------------------------------------------------------------------
    // Per-lane decode
    // ------------------------------------------------------------------
    logic [OUTPUT_WIDTH-1:0] w_lane_dat [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0]  w_full;
    logic [MATRIX_SIZE-1:0]  w_cnt_nz;
    logic [MATRIX_SIZE-1:0]  w_push;
    logic [MATRIX_SIZE-1:0]  w_drop;
    logic [MATRIX_SIZE-1:0]  w_pop;

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        // Lane 0 occupies the most significant slice of the packed bus.
        assign w_lane_dat[i] = QK_RESULT[(MATRIX_SIZE-i)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH];
        assign w_full[i]     = (r_count[i] == CNT_W'(DEPTH));
        assign w_cnt_nz[i]   = (r_count[i] != '0);
        // Fullness is judged on the registered count, so a pop in the same
        // cycle never makes room for a push into a full lane.
        assign w_push[i]     = write_enable[i] & ~w_full[i];
        assign w_drop[i]     = write_enable[i] &  w_full[i];
    end

    assign IS_FULL  = w_full;
    assign overflow = r_overflow;

    // ------------------------------------------------------------------
    // Round-robin selection: candidate k is lane (rr_ptr + k) mod MATRIX_SIZE
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] w_cand [MATRIX_SIZE];

    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_cand
        logic [LANE_W:0] w_sum;
        assign w_sum     = {1'b0, r_rr_ptr} + (LANE_W+1)'(k);
        assign w_cand[k] = (w_sum >= (LANE_W+1)'(MATRIX_SIZE))
                         ? LANE_W'(w_sum - (LANE_W+1)'(MATRIX_SIZE))
                         : LANE_W'(w_sum);
    end

    logic              w_any;
    logic [LANE_W-1:0] w_sel;

    // Walk candidates from farthest to nearest so the nearest non-empty lane
    // is the last assignment and therefore wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = MATRIX_SIZE - 1; k >= 0; k--) begin
            if (w_cnt_nz[w_cand[k]]) begin
                w_any = 1'b1;
                w_sel = w_cand[k];
            end
        end
    end

    // A new head is taken from IDLE whenever anything is stored, and from
    // SEND only when the current result is being accepted.
    logic                    w_take;
    logic [OUTPUT_WIDTH-1:0] w_head;
    logic [LANE_W-1:0]       w_rr_next;

    assign w_take    = w_any & ((r_state == ST_IDLE) | out_ready);
    assign w_head    = r_mem[w_sel][r_rd_ptr[w_sel]];
    assign w_rr_next = (w_sel == LANE_W'(MATRIX_SIZE - 1)) ? '0 : w_sel + LANE_W'(1);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            w_pop[i] = w_take & (w_sel == LANE_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Lane FIFO storage (contents need no reset: validity is tracked by count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_lane_dat[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane pointers, counts and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
            // A drop in the same cycle as a clear still leaves the bit set.
            r_overflow <= (clear_overflow ? '0 : r_overflow) | w_drop;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_out_data  <= w_head;
                        r_out_lane  <= w_sel;
                        r_out_valid <= 1'b1;
                        r_rr_ptr    <= w_rr_next;
                        r_state     <= ST_SEND;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (w_any) begin
                            r_out_data  <= w_head;
                            r_out_lane  <= w_sel;
                            r_out_valid <= 1'b1;
                            r_rr_ptr    <= w_rr_next;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;

endmodule

// File: tb/tb_qk_result_buffer.sv
// tb_qk_result_buffer: directed stimulus for qk_result_buffer with a per-lane scoreboard.
// Latency: outputs are compared on the negedge before the edge that accepts them.
// Backpressure: out_ready is driven per step to stall or drain the output.
module tb_qk_result_buffer;

    localparam int W = 9;
    localparam int M = 3;
    localparam int D = 4;

    logic           clk;
    logic           reset;
    logic [M-1:0]   write_enable;
    logic [M*W-1:0] QK_RESULT;
    logic [M-1:0]   IS_FULL;
    logic [M-1:0]   overflow;
    logic           clear_overflow;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_lane;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    int cyc      = 0;

    logic [W-1:0] sbq0 [$];
    logic [W-1:0] sbq1 [$];
    logic [W-1:0] sbq2 [$];
    logic [1:0]   exp_lane_q [$];
    int           out_cyc_q [$];

    qk_result_buffer #(
        .OUTPUT_WIDTH (W),
        .MATRIX_SIZE  (M),
        .DEPTH        (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .write_enable   (write_enable),
        .QK_RESULT      (QK_RESULT),
        .IS_FULL        (IS_FULL),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_lane       (out_lane)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a push on one lane; accepted pushes are recorded as expected output.
    task automatic drive_lane(input int l, input logic [W-1:0] v, input bit accepted);
        write_enable[l] = 1'b1;
        QK_RESULT[(M-l)*W-1 -: W] = v;
        if (accepted) begin
            case (l)
                0:       sbq0.push_back(v);
                1:       sbq1.push_back(v);
                default: sbq2.push_back(v);
            endcase
        end
    endtask

    task automatic check_output();
        logic [W-1:0] exp_v;
        logic [1:0]   exp_l;
        logic         found;
        n_out++;
        out_cyc_q.push_back(cyc);
        found = 1'b0;
        exp_v = '0;
        case (out_lane)
            2'd0: if (sbq0.size() > 0) begin exp_v = sbq0.pop_front(); found = 1'b1; end
            2'd1: if (sbq1.size() > 0) begin exp_v = sbq1.pop_front(); found = 1'b1; end
            2'd2: if (sbq2.size() > 0) begin exp_v = sbq2.pop_front(); found = 1'b1; end
            default: found = 1'b0;
        endcase
        chk("out_lane_has_data", 32'(found), 32'h1);
        if (found) chk("out_data", 32'(out_data), 32'(exp_v));
        if (exp_lane_q.size() > 0) begin
            exp_l = exp_lane_q.pop_front();
            chk("out_lane_order", 32'(out_lane), 32'(exp_l));
        end
    endtask

    // One clock: consume-check on the negedge, then step past the posedge.
    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) check_output();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int n_expected);
        int got0;
        got0 = n_out;
        out_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            tick();
            if ((n_out - got0) >= n_expected && out_valid === 1'b0) break;
        end
        chk({tag, "_drain_cnt"}, 32'(n_out - got0), 32'(n_expected));
        chk({tag, "_drain_idle"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        int start;
        int span;

        reset          = 1'b1;
        write_enable   = '0;
        QK_RESULT      = '0;
        clear_overflow = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_full",  32'(IS_FULL),   32'h0);
        chk("rst_ovf",   32'(overflow),  32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_lane",  32'(out_lane),  32'h0);

        // Single push on lane 1, consumer ready.
        reset     = 1'b0;
        out_ready = 1'b1;
        drive_lane(1, 9'h005, 1'b1);
        exp_lane_q.push_back(2'd1);
        tick();
        write_enable = '0;
        chk("s1_valid_at_push", 32'(out_valid), 32'h0);
        tick();
        chk("s1_valid", 32'(out_valid), 32'h1);
        chk("s1_data",  32'(out_data),  32'h005);
        chk("s1_lane",  32'(out_lane),  32'h1);
        tick();
        chk("s1_valid_after", 32'(out_valid), 32'h0);
        chk("s1_consumed", 32'(n_out), 32'h1);

        // Park one lane-2 entry in the output register, then fill all lanes while stalled.
        out_ready = 1'b0;
        drive_lane(2, 9'h0AA, 1'b1);
        tick();
        write_enable = '0;
        tick();
        chk("s2_prime_valid", 32'(out_valid), 32'h1);
        chk("s2_prime_lane",  32'(out_lane),  32'h2);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < M; l++) drive_lane(l, 9'(9'h100 + l*16 + k), 1'b1);
            tick();
            chk("s2_full_progress", 32'(IS_FULL), (k == 3) ? 32'h7 : 32'h0);
            chk("s2_hold_data",  32'(out_data),  32'h0AA);
            chk("s2_hold_lane",  32'(out_lane),  32'h2);
            chk("s2_hold_valid", 32'(out_valid), 32'h1);
        end
        for (int l = 0; l < M; l++) drive_lane(l, 9'h1FF, 1'b0);
        tick();
        write_enable = '0;
        chk("s2_ovf",       32'(overflow), 32'h7);
        chk("s2_full_kept", 32'(IS_FULL),  32'h7);
        chk("s2_hold_data5", 32'(out_data), 32'h0AA);

        clear_overflow = 1'b1;
        tick();
        chk("s2_ovf_cleared", 32'(overflow), 32'h0);
        drive_lane(0, 9'h1FE, 1'b0);
        tick();
        write_enable = '0;
        chk("s2_ovf_clear_vs_drop", 32'(overflow), 32'h1);
        tick();
        clear_overflow = 1'b0;
        chk("s2_ovf_cleared2", 32'(overflow), 32'h0);

        // Drain: parked entry, then 12 round-robin outputs back to back.
        exp_lane_q.push_back(2'd2);
        for (int r = 0; r < 4; r++) begin
            exp_lane_q.push_back(2'd0);
            exp_lane_q.push_back(2'd1);
            exp_lane_q.push_back(2'd2);
        end
        start = out_cyc_q.size();
        drain("s3", 13);
        span = (out_cyc_q.size() >= start + 13) ? out_cyc_q[start+12] - out_cyc_q[start] : -1;
        chk("s3_back_to_back", 32'(span), 32'd12);
        chk("s3_sb_empty", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'h0);

        // Lane 2 full; pop it and push it in the same cycle.
        out_ready = 1'b0;
        drive_lane(0, 9'h0C0, 1'b1);
        exp_lane_q.push_back(2'd0);
        tick();
        write_enable = '0;
        tick();
        chk("s4_prime_lane", 32'(out_lane), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive_lane(2, 9'(9'h020 + k), 1'b1);
            exp_lane_q.push_back(2'd2);
            tick();
        end
        chk("s4_full", 32'(IS_FULL), 32'h4);
        drive_lane(2, 9'h1EE, 1'b0);
        out_ready = 1'b1;
        tick();
        write_enable = '0;
        chk("s4_ovf",        32'(overflow),  32'h4);
        chk("s4_not_full",   32'(IS_FULL),   32'h0);
        chk("s4_pop_lane",   32'(out_lane),  32'h2);
        chk("s4_pop_data",   32'(out_data),  32'h020);
        drain("s4", 4);
        chk("s4_sb_empty", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'h0);

        // Reset while presenting with two entries still stored.
        out_ready = 1'b0;
        for (int l = 0; l < M; l++) drive_lane(l, 9'(9'h0D0 + l), 1'b1);
        tick();
        write_enable = '0;
        tick();
        chk("s5_send_valid", 32'(out_valid), 32'h1);
        chk("s5_send_lane",  32'(out_lane),  32'h0);
        reset = 1'b1;
        for (int l = 0; l < M; l++) drive_lane(l, 9'h1AA, 1'b0);
        tick();
        chk("s5_rst_valid", 32'(out_valid), 32'h0);
        chk("s5_rst_full",  32'(IS_FULL),   32'h0);
        chk("s5_rst_ovf",   32'(overflow),  32'h0);
        chk("s5_rst_data",  32'(out_data),  32'h0);
        chk("s5_rst_lane",  32'(out_lane),  32'h0);
        reset        = 1'b0;
        write_enable = '0;
        sbq0.delete();
        sbq1.delete();
        sbq2.delete();
        exp_lane_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s5_no_stale", 32'(out_valid), 32'h0);
        end
        drive_lane(2, 9'h0E2, 1'b1);
        drive_lane(0, 9'h0E1, 1'b1);
        exp_lane_q.push_back(2'd0);
        exp_lane_q.push_back(2'd2);
        tick();
        write_enable = '0;
        drain("s5", 2);
        chk("s5_sb_empty", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qk_result_buffer.md
QK_RESULT_BUFFER -- requirements
Module: qk_result_buffer

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 9, SHALL set the bit width of one lane's QK result.
REQ-002 Parameter MATRIX_SIZE, default 3, SHALL set the number of lanes (one per PE-array output column).
REQ-003 Parameter DEPTH, default 4, SHALL set the per-lane FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 write_enable  in  MATRIX_SIZE  SHALL carry the per-lane push request, with bit i for lane i.
REQ-007 QK_RESULT  in  MATRIX_SIZE*OUTPUT_WIDTH  SHALL carry the lane data; lane i SHALL be bits [(MATRIX_SIZE-i)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH], so lane 0 is the MSB slice.
REQ-008 IS_FULL  out  MATRIX_SIZE  SHALL be high on bit i when lane i holds DEPTH entries.
REQ-009 overflow  out  MATRIX_SIZE  SHALL be a sticky per-lane flag indicating that a push was dropped.
REQ-010 clear_overflow  in  1  SHALL clear all overflow bits on the next edge when high.
REQ-011 out_valid  out  1  SHALL indicate that out_data and out_lane are valid.
REQ-012 out_ready  in  1  SHALL be the consumer ready signal.
REQ-013 out_data  out  OUTPUT_WIDTH  SHALL carry the popped result.
REQ-014 out_lane  out  $clog2(MATRIX_SIZE)  SHALL carry the lane index of out_data.

Function
REQ-015 Each lane SHALL be an independent FIFO with DEPTH entries, a write pointer, a read pointer and a count from 0 to DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-016 A push SHALL occur on lane i when write_enable[i] is high and IS_FULL[i] is low at the edge; multiple lanes MAY push in the same cycle.
REQ-017 A push attempted while IS_FULL[i] is high SHALL be dropped and SHALL set overflow[i], even if lane i pops in the same cycle.
REQ-018 If clear_overflow is high and a new overflow occurs in the same cycle, the overflow bit SHALL end set.
REQ-019 IS_FULL SHALL be decoded from registered counts only, with no combinational path from write_enable or out_ready.
REQ-020 A simultaneous push and pop on the same non-full lane SHALL leave the count unchanged while moving both pointers.
REQ-021 The output FSM SHALL have two states, IDLE and SEND, and SHALL keep a round-robin pointer rr_ptr in the range 0..MATRIX_SIZE-1.
REQ-022 Selection rule: the first lane with count>0 searching rr_ptr, rr_ptr+1, ... (mod MATRIX_SIZE); on selection that lane's head SHALL be popped into the out_data/out_lane registers and rr_ptr SHALL become (selected+1) mod MATRIX_SIZE.
REQ-023 In IDLE with any count>0, the FSM SHALL select a lane, set out_valid=1 and go to SEND; otherwise it SHALL stay in IDLE with out_valid=0.
REQ-024 In SEND with out_ready=0, out_valid, out_data and out_lane SHALL hold stable.
REQ-025 In SEND with out_ready=1 and any count>0 (counts evaluated before this edge's pushes), the FSM SHALL select and pop again, stay in SEND, and keep out_valid=1, giving one result per cycle.
REQ-026 In SEND with out_ready=1 and all counts 0, the FSM SHALL set out_valid=0 and return to IDLE.
REQ-027 Latency: a push at edge N SHALL make out_valid high after edge N+1 when the buffer was otherwise empty and in IDLE.
REQ-028 No pop SHALL ever occur on an empty lane, and no entry SHALL be lost or duplicated except dropped overflow pushes.

Reset
REQ-029 When reset is high at an edge, all counts and pointers, rr_ptr, out_data, out_lane, out_valid and overflow SHALL become 0 and the FSM SHALL enter IDLE, regardless of other inputs.
REQ-030 After reset, IS_FULL SHALL be 0; a reset asserted mid-transfer SHALL discard all stored and presented data.

Verification
REQ-031 The bench SHALL cover: reset, then one push on lane 1 with value 0x05 and out_ready=1 -> out_valid high one cycle after the push, out_data=0x05, out_lane=1, then out_valid=0.
REQ-032 The bench SHALL cover: all 3 lanes push every cycle for 4 cycles with out_ready=0 -> IS_FULL=3'b111, a 5th push sets overflow=3'b111, and the counts stay 4.
REQ-033 The bench SHALL cover: all lanes full, then out_ready=1 -> 12 outputs on consecutive cycles with lane order 0,1,2,0,1,2,... and per-lane FIFO order preserved.
REQ-034 The bench SHALL cover: lane 2 full, pop lane 2 and push lane 2 in the same cycle -> the push is dropped, overflow[2]=1, count=3.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles while out_valid=1 -> out_data and out_lane stay stable and no count changes except from pushes.
REQ-036 The bench SHALL cover: reset asserted while in SEND with 2 entries stored -> the next cycle shows out_valid=0, IS_FULL=0, and no stale data afterward.
